// File: rtl/mem_ctrl.sv
// Byte-wide RAM controller arbitrating instruction fetch and load/store traffic.
// Multi-byte transfers are sequenced one byte per cycle, little-endian.
module mem_ctrl #(
    parameter int unsigned RAM_AW = 17
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              if_req_in,
    input  logic [31:0]       if_addr_in,
    output logic              if_done_out,
    output logic [31:0]       if_inst_out,
    input  logic              mem_req_in,
    input  logic              mem_we_in,
    input  logic [1:0]        mem_len_in,
    input  logic [31:0]       mem_addr_in,
    input  logic [31:0]       mem_wdata_in,
    output logic              mem_done_out,
    output logic [31:0]       mem_rdata_out,
    input  logic [7:0]        ram_din_in,
    output logic [7:0]        ram_dout_out,
    output logic [RAM_AW-1:0] ram_a_out,
    output logic              ram_wr_out
);

    typedef enum logic [2:0] {
        StIdle,
        StIfRd,
        StMemRd,
        StMemWr,
        StDone
    } state_e;

    state_e      r_state;
    state_e      w_state_d;
    logic [2:0]  r_cnt;
    logic [2:0]  r_n;
    logic [31:0] r_base;
    logic [31:0] r_wdata;
    logic        r_is_if;
    logic [31:0] r_buf;
    logic [31:0] r_if_inst;
    logic [31:0] r_mem_rdata;

    logic [31:0] w_addr;
    logic [2:0]  w_cnt_m1;
    logic [31:0] w_buf_new;
    logic [31:0] w_wshift;

    assign w_addr   = r_base + {29'd0, r_cnt};
    assign w_cnt_m1 = r_cnt - 3'd1;
    // Byte captured now belongs to the address driven one cycle earlier.
    assign w_buf_new = r_buf | ({24'd0, ram_din_in} << {w_cnt_m1[1:0], 3'b000});
    assign w_wshift  = r_wdata >> {r_cnt[1:0], 3'b000};

    assign if_inst_out   = r_if_inst;
    assign mem_rdata_out = r_mem_rdata;

    always_comb begin
        w_state_d    = r_state;
        ram_wr_out   = 1'b0;
        ram_a_out    = '0;
        ram_dout_out = 8'd0;
        if_done_out  = 1'b0;
        mem_done_out = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (mem_req_in) begin
                    w_state_d = mem_we_in ? StMemWr : StMemRd;
                end else if (if_req_in) begin
                    w_state_d = StIfRd;
                end
            end
            StIfRd: begin
                ram_a_out = w_addr[RAM_AW-1:0];
                if (!if_req_in) begin
                    w_state_d = StIdle;
                end else if (r_cnt == r_n) begin
                    w_state_d = StDone;
                end
            end
            StMemRd: begin
                ram_a_out = w_addr[RAM_AW-1:0];
                if (r_cnt == r_n) begin
                    w_state_d = StDone;
                end
            end
            StMemWr: begin
                ram_wr_out   = 1'b1;
                ram_a_out    = w_addr[RAM_AW-1:0];
                ram_dout_out = w_wshift[7:0];
                if (r_cnt == r_n - 3'd1) begin
                    w_state_d = StDone;
                end
            end
            StDone: begin
                if_done_out  = r_is_if;
                mem_done_out = !r_is_if;
                w_state_d    = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state     <= StIdle;
            r_cnt       <= 3'd0;
            r_n         <= 3'd0;
            r_base      <= 32'd0;
            r_wdata     <= 32'd0;
            r_is_if     <= 1'b0;
            r_buf       <= 32'd0;
            r_if_inst   <= 32'd0;
            r_mem_rdata <= 32'd0;
        end else begin
            r_state <= w_state_d;
            unique case (r_state)
                StIdle: begin
                    r_cnt <= 3'd0;
                    r_buf <= 32'd0;
                    if (mem_req_in) begin
                        r_base  <= mem_addr_in;
                        r_wdata <= mem_wdata_in;
                        r_is_if <= 1'b0;
                        unique case (mem_len_in)
                            2'b00:   r_n <= 3'd1;
                            2'b01:   r_n <= 3'd2;
                            default: r_n <= 3'd4;
                        endcase
                    end else if (if_req_in) begin
                        r_base  <= if_addr_in;
                        r_is_if <= 1'b1;
                        r_n     <= 3'd4;
                    end
                end
                StIfRd, StMemRd: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt != 3'd0) begin
                        r_buf <= w_buf_new;
                    end
                    // Result registers move only when the transfer completes.
                    if (w_state_d == StDone) begin
                        if (r_is_if) begin
                            r_if_inst <= w_buf_new;
                        end else begin
                            r_mem_rdata <= w_buf_new;
                        end
                    end
                end
                StMemWr: r_cnt <= r_cnt + 3'd1;
                StDone:  r_cnt <= 3'd0;
                default: r_cnt <= 3'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: vector table, corner sequences and random traffic
// checked against a byte-array memory model.
module tb_mem_ctrl;

    localparam int AW = 17;
    localparam int RAM_SIZE = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [31:0]   if_addr = 32'd0;
    logic          if_done;
    logic [31:0]   if_inst;
    logic          mem_req = 1'b0;
    logic          mem_we = 1'b0;
    logic [1:0]    mem_len = 2'd0;
    logic [31:0]   mem_addr = 32'd0;
    logic [31:0]   mem_wdata = 32'd0;
    logic          mem_done;
    logic [31:0]   mem_rdata;
    logic [7:0]    ram_din = 8'd0;
    logic [7:0]    ram_dout;
    logic [AW-1:0] ram_a;
    logic          ram_wr;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0]  ram     [RAM_SIZE];
    logic [7:0]  exp_mem [RAM_SIZE];
    bit          ram_init_done = 1'b0;
    logic [31:0] exp_if_inst = 32'd0;
    logic [31:0] exp_mem_rdata = 32'd0;

    mem_ctrl #(.RAM_AW(AW)) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .if_req_in     (if_req),
        .if_addr_in    (if_addr),
        .if_done_out   (if_done),
        .if_inst_out   (if_inst),
        .mem_req_in    (mem_req),
        .mem_we_in     (mem_we),
        .mem_len_in    (mem_len),
        .mem_addr_in   (mem_addr),
        .mem_wdata_in  (mem_wdata),
        .mem_done_out  (mem_done),
        .mem_rdata_out (mem_rdata),
        .ram_din_in    (ram_din),
        .ram_dout_out  (ram_dout),
        .ram_a_out     (ram_a),
        .ram_wr_out    (ram_wr)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(input int i);
        case (i)
            32'h100:   return 8'h13;
            32'h101:   return 8'h05;
            32'h102:   return 8'h10;
            32'h103:   return 8'h00;
            32'h200:   return 8'h34;
            32'h201:   return 8'h12;
            32'h1FFFE: return 8'h5A;
            32'h1FFFF: return 8'h99;
            32'h0:     return 8'h11;
            32'h1:     return 8'h22;
            default:   return 8'((i * 37 + 11) ^ (i >> 8));
        endcase
    endfunction

    // Synchronous RAM: the byte for the address seen at an edge appears after it.
    always @(posedge clk) begin
        if (!ram_init_done) begin
            for (int i = 0; i < RAM_SIZE; i++) ram[i] <= init_val(i);
            ram_init_done <= 1'b1;
        end else begin
            ram_din <= ram[ram_a];
            if (ram_wr) ram[ram_a] <= ram_dout;
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    function automatic int len_bytes(input logic [1:0] len);
        return (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
        logic [31:0] r = 32'd0;
        for (int k = 0; k < n; k++) begin
            logic [31:0] ak = a + k;
            r = r | ({24'd0, exp_mem[ak[AW-1:0]]} << (8 * k));
        end
        return r;
    endfunction

    // Issue one request at a negedge of an IDLE cycle; returns at a negedge of the next IDLE cycle.
    task automatic run_txn(input string nm, input bit is_if, input bit we, input logic [1:0] len,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] exp_d, input int exp_lat);
        int  n = is_if ? 4 : len_bytes(len);
        bit  wr = we && !is_if;
        bit  done = 1'b0;
        if (is_if) begin
            if_req  = 1'b1;
            if_addr = addr;
        end else begin
            mem_req   = 1'b1;
            mem_we    = we;
            mem_len   = len;
            mem_addr  = addr;
            mem_wdata = wdata;
        end
        for (int c = 1; c <= 20 && !done; c++) begin
            @(negedge clk);
            if (c <= n) begin
                logic [31:0] ea = addr + (c - 1);
                logic [31:0] wb = wdata >> (8 * (c - 1));
                check({nm, " ram_a"}, 32'(ram_a), 32'(ea[AW-1:0]));
                check({nm, " ram_wr"}, 32'(ram_wr), 32'(wr));
                if (wr) check({nm, " ram_dout"}, 32'(ram_dout), 32'(wb[7:0]));
            end
            if (if_done || mem_done) begin
                done = 1'b1;
                check({nm, " done sel"}, {30'd0, if_done, mem_done}, is_if ? 32'd2 : 32'd1);
                check({nm, " latency"}, 32'(c), 32'(exp_lat));
                if (is_if) exp_if_inst = exp_d;
                else if (!we) exp_mem_rdata = exp_d;
                check({nm, " if_inst"}, if_inst, exp_if_inst);
                check({nm, " mem_rdata"}, mem_rdata, exp_mem_rdata);
            end
        end
        if (!done) check({nm, " done timeout"}, 32'd0, 32'd1);
        if_req  = 1'b0;
        mem_req = 1'b0;
        if (wr) begin
            for (int k = 0; k < n; k++) begin
                logic [31:0] ak = addr + k;
                logic [31:0] wb = wdata >> (8 * k);
                exp_mem[ak[AW-1:0]] = wb[7:0];
            end
        end
        @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string nm);
        check({nm, " ram_wr"}, 32'(ram_wr), 32'd0);
        check({nm, " ram_a"}, 32'(ram_a), 32'd0);
        check({nm, " ram_dout"}, 32'(ram_dout), 32'd0);
        check({nm, " dones"}, {30'd0, if_done, mem_done}, 32'd0);
        check({nm, " if_inst"}, if_inst, exp_if_inst);
        check({nm, " mem_rdata"}, mem_rdata, exp_mem_rdata);
    endtask

    typedef struct {
        bit          is_if;
        bit          we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_d;
        int          exp_lat;
    } vec_t;

    vec_t tbl[11];

    initial begin
        bit seen;
        int cnt;
        for (int i = 0; i < RAM_SIZE; i++) exp_mem[i] = init_val(i);

        tbl[0]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h0,         32'h0010_0513, 6};
        tbl[1]  = '{1'b0, 1'b1, 2'b00, 32'h0001_FFFF, 32'hAABB_CCDD, 32'h0,         2};
        tbl[2]  = '{1'b0, 1'b0, 2'b00, 32'h0001_FFFF, 32'h0,         32'h0000_00DD, 3};
        tbl[3]  = '{1'b0, 1'b0, 2'b00, 32'h0001_FFFE, 32'h0,         32'h0000_005A, 3};
        tbl[4]  = '{1'b0, 1'b0, 2'b01, 32'h0000_0200, 32'h0,         32'h0000_1234, 4};
        tbl[5]  = '{1'b0, 1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0,         32'h2211_DD5A, 6};
        tbl[6]  = '{1'b0, 1'b1, 2'b10, 32'h0000_0300, 32'hCAFE_F00D, 32'h0,         5};
        tbl[7]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0300, 32'h0,         32'hCAFE_F00D, 6};
        tbl[8]  = '{1'b0, 1'b1, 2'b01, 32'h0000_0302, 32'h1234_5678, 32'h0,         3};
        tbl[9]  = '{1'b0, 1'b0, 2'b11, 32'h0000_0300, 32'h0,         32'h5678_F00D, 6};
        tbl[10] = '{1'b0, 1'b0, 2'b01, 32'h0000_0301, 32'h0,         32'h0000_78F0, 4};

        // Reset state
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("post-reset");

        for (int i = 0; i < 11; i++) begin
            run_txn($sformatf("vec%0d", i), tbl[i].is_if, tbl[i].we, tbl[i].len, tbl[i].addr,
                    tbl[i].wdata, tbl[i].exp_d, tbl[i].exp_lat);
        end

        // IF abort in the second fetch cycle
        if_req  = 1'b1;
        if_addr = 32'h300;
        @(negedge clk);
        @(negedge clk);
        if_req = 1'b0;
        @(negedge clk);
        check_idle_outputs("abort idle");
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (if_done) seen = 1'b1;
        end
        check("abort no done", 32'(seen), 32'd0);
        check("abort if_inst held", if_inst, exp_if_inst);
        run_txn("after abort", 1'b1, 1'b0, 2'b10, 32'h300, 32'h0, model_read(32'h300, 4), 6);

        // Simultaneous requests: MEM first, then the fetch
        if_req   = 1'b1;
        if_addr  = 32'h100;
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_len  = 2'b01;
        mem_addr = 32'h200;
        seen = 1'b0;
        cnt  = 0;
        for (int c = 1; c <= 20 && cnt == 0; c++) begin
            @(negedge clk);
            if (if_done) seen = 1'b1;
            if (mem_done) cnt = c;
        end
        check("both: if_done early", 32'(seen), 32'd0);
        check("both: mem latency", 32'(cnt), 32'd4);
        check("both: mem_rdata", mem_rdata, 32'h0000_1234);
        exp_mem_rdata = 32'h0000_1234;
        mem_req = 1'b0;
        cnt = 0;
        for (int c = 1; c <= 20 && cnt == 0; c++) begin
            @(negedge clk);
            if (if_done) cnt = c;
        end
        check("both: if gap+latency", 32'(cnt), 32'd7);
        check("both: if_inst", if_inst, 32'h0010_0513);
        exp_if_inst = 32'h0010_0513;
        if_req = 1'b0;
        @(negedge clk);

        // Reset during the third byte of a word store
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_len   = 2'b10;
        mem_addr  = 32'h400;
        mem_wdata = 32'h4433_2211;
        repeat (3) @(negedge clk);
        check("rst: 3rd byte addr", 32'(ram_a), 32'h402);
        rst = 1'b1;
        @(negedge clk);
        exp_if_inst   = 32'd0;
        exp_mem_rdata = 32'd0;
        check_idle_outputs("rst mid-store");
        rst     = 1'b0;
        mem_req = 1'b0;
        exp_mem[17'h400] = 8'h11;
        exp_mem[17'h401] = 8'h22;
        exp_mem[17'h402] = 8'h33;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (mem_done || ram_wr) seen = 1'b1;
        end
        check("rst: no done/write", 32'(seen), 32'd0);
        run_txn("partial word", 1'b0, 1'b0, 2'b10, 32'h400, 32'h0, model_read(32'h400, 4), 6);
        run_txn("store after rst", 1'b0, 1'b1, 2'b10, 32'h400, 32'hDEAD_BEEF, 32'h0, 5);
        run_txn("load after rst", 1'b0, 1'b0, 2'b10, 32'h400, 32'h0, 32'hDEAD_BEEF, 6);

        // Random traffic against the memory model
        for (int i = 0; i < 60; i++) begin
            bit          r_if = ($urandom_range(0, 3) == 0);
            bit          r_we = 1'($urandom_range(0, 1));
            logic [1:0]  r_len = 2'($urandom_range(0, 3));
            logic [31:0] r_addr = $urandom_range(0, 1) ? $urandom : 32'h1000 + $urandom_range(0, 255);
            logic [31:0] r_wd = $urandom;
            int          n = r_if ? 4 : len_bytes(r_len);
            bit          is_wr = r_we && !r_if;
            logic [31:0] ed = is_wr ? 32'd0 : model_read(r_addr, n);
            run_txn($sformatf("rand%0d", i), r_if, r_we, r_len, r_addr, r_wd, ed,
                    is_wr ? n + 1 : n + 2);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single-port memory controller that shares the byte-wide RAM between the instruction-fetch stage (IF) and the load/store stage (MEM).
- Arbitrates requests between the two, sequences multi-byte transfers one byte per cycle, and assembles or splits 32-bit words in little-endian order.
- Sits between the pipeline stages and the external RAM.
- Its done strobes release IF/MEM stalls.

Parameters:
- RAM_AW, 17, width of RAM address output; internal addresses are 32-bit, and the low RAM_AW bits are driven.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous, active-high reset
- if_req_in  in  1  IF fetch request (level, held until done or abort)
- if_addr_in  in  32  fetch address
- if_done_out  out  1  one-cycle pulse: if_inst_out valid
- if_inst_out  out  32  fetched instruction, held until next if_done_out
- mem_req_in  in  1  MEM access request (level, held until done)
- mem_we_in  in  1  1 = store, 0 = load
- mem_len_in  in  2  00 = byte, 01 = half, 10 = word, 11 = word
- mem_addr_in  in  32  access base address
- mem_wdata_in  in  32  store data, low bytes used
- mem_done_out  out  1  one-cycle pulse: access complete
- mem_rdata_out  out  32  load data, zero-extended, held until next mem_done_out
- ram_din_in  in  8  RAM read data; byte for the address driven in cycle c is valid in cycle c+1
- ram_dout_out  out  8  RAM write data
- ram_a_out  out  RAM_AW  RAM address
- ram_wr_out  out  1  RAM write enable (1 = write)

Behaviour:
- **Reset** (rst_in high at edge): state IDLE, byte counter 0, and every output 0. Reset takes effect on the next edge, even mid-transfer; a partially written word stays partially written, and no done pulse is issued.
- **States:** IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
- **IDLE:** ram_wr_out = 0, ram_a_out = 0.
  - Requests are sampled only in IDLE.
  - If mem_req_in is high, latch mem_addr/we/len/wdata and go to MEM_WR (we = 1) or MEM_RD (we = 0). MEM has fixed priority over IF.
  - Else if if_req_in is high, latch if_addr_in, N = 4, and go to IF_RD.
- **Byte count N:** 1, 2 or 4 from mem_len_in; 11 is treated as 4.
- **Addresses:** byte k (k = 0..N-1) uses address base+k, modulo 2^32, truncated to RAM_AW. No alignment check.
- **Reads (IF_RD/MEM_RD), request sampled in cycle T:**
  - ram_a_out = base+k in cycle T+1+k.
  - Byte k is captured from ram_din_in at the end of cycle T+2+k into bits [8k+7:8k].
  - After byte N-1 is captured, enter DONE. The done pulse occurs in cycle T+N+2, so a word fetch completes at T+6 and a byte load at T+3.
  - Unread upper bytes of mem_rdata_out are 0.
- **Writes (MEM_WR):**
  - In cycles T+1..T+N: ram_wr_out = 1, ram_a_out = base+k, ram_dout_out = wdata[8k+7:8k].
  - Then DONE; the done pulse occurs in cycle T+N+1.
  - ram_wr_out is 0 in every other state.
- **DONE:** the matching done output is high for exactly this one cycle, with no RAM access and no request sampling; the next state is IDLE.
  - Requesters deassert or change the request in the cycle after done, so back-to-back requests restart from IDLE, giving a minimum one-cycle gap.
- **IF abort:** if if_req_in is low in any IF_RD cycle, the next state is IDLE, with no if_done_out and if_inst_out unchanged. Used on branch flush; a pending mem_req_in is then served.
- **MEM transfers are not abortable;** mem_req_in dropping mid-transfer is ignored.
- **Output data registers** change only on the cycle that enters DONE.
- **Both requests high while busy:** the current transfer finishes, then MEM wins in the next IDLE.

Test Plan:
- Word fetch: if_req_in = 1, if_addr_in = 0x100, RAM[0x100..0x103] = 13,05,10,00 -> ram_a_out 0x100..0x103 on consecutive cycles; if_done_out pulses 6 cycles after request, if_inst_out = 0x00100513.
- Byte store: mem_req_in = 1, we = 1, len = 00, addr = 0x1FFFF, wdata = 0xAABBCCDD -> exactly one write cycle with ram_a_out = 0x1FFFF, ram_dout_out = 0xDD; mem_done_out 2 cycles after request; RAM[0x1FFFE] untouched.
- Simultaneous request: if_req_in and mem_req_in (load half at 0x200 = 34,12) both high in IDLE -> MEM served first, mem_rdata_out = 0x00001234; the fetch starts after DONE→IDLE, and if_done_out follows.
- IF abort: drop if_req_in in the 2nd IF_RD cycle -> IDLE next cycle, no if_done_out, if_inst_out retains its old value; a following request fetches correctly.
- Reset mid-store: rst_in high during the 3rd byte of a word store -> ram_wr_out = 0 and all outputs 0 from the next cycle; no mem_done_out; a new store completes normally.
- Address wrap: word load at 0xFFFFFFFE -> ram_a_out sequence low bits of 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
